uart_fifo_bridge: RTL and testbench

UART_FIFO_BRIDGE -- requirements
Module: uart_fifo_bridge

---
 rtl/uart_fifo_bridge_if.sv | 31 +++
 rtl/uart_fifo_bridge.sv | 113 +++++++++++
 tb/tb_uart_fifo_bridge.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_fifo_bridge_if.sv
// Bundle between a UART receiver/transmitter pair and the FIFO bridge.
// The bridge is the slave; the surrounding UART logic (or a bench) is the master.
interface uart_fifo_bridge_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  // rx_data_ready is a one-cycle strobe qualifying rx_data with no backpressure;
  // tx_start is a one-cycle request carrying tx_data, and the transmitter
  // acknowledges by raising tx_busy and completes by dropping it.
  logic                     rx_data_ready;
  logic [DATA_W-1:0]        rx_data;
  logic                     send;
  logic                     tx_busy;
  logic                     clr_ovf;
  logic                     tx_start;
  logic [DATA_W-1:0]        tx_data;
  logic [$clog2(DEPTH):0]   count;
  logic                     empty;
  logic                     full;
  logic                     overflow;

  modport master (
    output rx_data_ready, rx_data, send, tx_busy, clr_ovf,
    input  tx_start, tx_data, count, empty, full, overflow
  );

  modport slave (
    input  rx_data_ready, rx_data, send, tx_busy, clr_ovf,
    output tx_start, tx_data, count, empty, full, overflow
  );
endinterface

// File: rtl/uart_fifo_bridge.sv
// Buffers received UART characters in a FIFO and forwards them to the
// transmitter on a send pulse, one character or a full drain per pulse.
module uart_fifo_bridge #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int BURST  = 0
) (
  input  logic              clk,
  input  logic              rst,
  uart_fifo_bridge_if.slave bus,
  output logic [1:0]        state_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t            state_q;
  logic              tx_start_q;
  logic [DATA_W-1:0] tx_data_q;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;

  logic empty, full, pop, accept, drop;

  assign empty  = (count_q == '0);
  assign full   = (count_q == CNT_W'(DEPTH));
  assign pop    = (state_q == START);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign accept = bus.rx_data_ready && (!full || pop);
  assign drop   = bus.rx_data_ready && full && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = (overflow_q && !bus.clr_ovf) || drop;
    if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && accept) mem_q[wr_ptr_q] <= bus.rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // The head is captured on entry to START, so a same-cycle push into a full
  // FIFO may overwrite that slot without corrupting the character being sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.send && !empty) begin
            state_q    <= START;
            tx_start_q <= 1'b1;
            tx_data_q  <= mem_q[rd_ptr_q];
          end
        end
        START: state_q <= WAIT_BUSY;
        WAIT_BUSY: begin
          if (bus.tx_busy) state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            if (BURST != 0 && !empty) begin
              state_q    <= START;
              tx_start_q <= 1'b1;
              tx_data_q  <= mem_q[rd_ptr_q];
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.count    = count_q;
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.overflow = overflow_q;
  assign state_o      = state_q;
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Bench for uart_fifo_bridge: a DEPTH=4/BURST=0 instance (index 0) and a
// DEPTH=16/BURST=1 instance (index 1), each with a transmitter model and scoreboard.
module tb_uart_fifo_bridge;
  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   busy_len = 10;

  logic [1:0]      rx_rdy;
  logic [1:0][7:0] rx_d;
  logic [1:0]      send_v;
  logic [1:0]      clr_v;
  logic [1:0]      man_mode;
  logic [1:0]      man_busy;

  wire [1:0]      txs_w;
  wire [1:0][7:0] txd_w;
  wire [1:0][4:0] cnt_w;
  wire [1:0]      emp_w;
  wire [1:0]      full_w;
  wire [1:0]      ovf_w;
  wire [1:0]      busy_w;
  wire [1:0][1:0] state_w;

  int bcnt [2];

  uart_fifo_bridge_if #(.DATA_W(8), .DEPTH(4))  if_a ();
  uart_fifo_bridge_if #(.DATA_W(8), .DEPTH(16)) if_b ();

  uart_fifo_bridge #(.DATA_W(8), .DEPTH(4), .BURST(0)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave), .state_o(state_w[0])
  );
  uart_fifo_bridge #(.DATA_W(8), .DEPTH(16), .BURST(1)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave), .state_o(state_w[1])
  );

  assign busy_w[0] = man_mode[0] ? man_busy[0] : (bcnt[0] != 0);
  assign busy_w[1] = man_mode[1] ? man_busy[1] : (bcnt[1] != 0);

  assign if_a.rx_data_ready = rx_rdy[0];
  assign if_a.rx_data       = rx_d[0];
  assign if_a.send          = send_v[0];
  assign if_a.clr_ovf       = clr_v[0];
  assign if_a.tx_busy       = busy_w[0];
  assign if_b.rx_data_ready = rx_rdy[1];
  assign if_b.rx_data       = rx_d[1];
  assign if_b.send          = send_v[1];
  assign if_b.clr_ovf       = clr_v[1];
  assign if_b.tx_busy       = busy_w[1];

  assign txs_w[0]  = if_a.tx_start;
  assign txd_w[0]  = if_a.tx_data;
  assign cnt_w[0]  = {2'b00, if_a.count};
  assign emp_w[0]  = if_a.empty;
  assign full_w[0] = if_a.full;
  assign ovf_w[0]  = if_a.overflow;
  assign txs_w[1]  = if_b.tx_start;
  assign txd_w[1]  = if_b.tx_data;
  assign cnt_w[1]  = if_b.count;
  assign emp_w[1]  = if_b.empty;
  assign full_w[1] = if_b.full;
  assign ovf_w[1]  = if_b.overflow;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter model: busy for busy_len cycles starting the cycle after tx_start.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst)           bcnt[i] <= 0;
      else if (txs_w[i]) bcnt[i] <= busy_len;
      else if (bcnt[i] != 0) bcnt[i] <= bcnt[i] - 1;
    end
  end

  // Scoreboard: queue of accepted characters plus a transaction-level view
  // of when the next transmit request is due.
  for (genvar g = 0; g < 2; g++) begin : g_sb
    localparam int MD = (g == 0) ? 4 : 16;
    localparam bit MB = (g == 1);
    logic [7:0] exp_q[$];
    bit         valid = 1'b0;
    bit         ovf_m, in_flight, busy_seen, start_due;
    logic [7:0] last_tx;
    int         n_tx = 0;

    always @(negedge clk) begin
      int sz;
      bit pop_m, drop_m, nxt;
      sz = exp_q.size();
      if (valid) begin
        n_tests++;
        if (txs_w[g] !== start_due) begin
          n_fail++;
          $display("FAIL sb%0d_tx_start got %b required %b at %0t", g, txs_w[g], start_due, $time);
        end
        n_tests++;
        if (start_due) begin
          if (txd_w[g] !== exp_q[0]) begin
            n_fail++;
            $display("FAIL sb%0d_tx_data got %h required %h at %0t", g, txd_w[g], exp_q[0], $time);
          end
        end else if (txd_w[g] !== last_tx) begin
          n_fail++;
          $display("FAIL sb%0d_tx_data_hold got %h required %h at %0t", g, txd_w[g], last_tx, $time);
        end
        n_tests++;
        if (cnt_w[g] !== 5'(sz)) begin
          n_fail++;
          $display("FAIL sb%0d_count got %0d required %0d at %0t", g, cnt_w[g], sz, $time);
        end
        n_tests++;
        if (ovf_w[g] !== ovf_m) begin
          n_fail++;
          $display("FAIL sb%0d_overflow got %b required %b at %0t", g, ovf_w[g], ovf_m, $time);
        end
        n_tests++;
        if ({emp_w[g], full_w[g]} !== {sz == 0, sz == MD}) begin
          n_fail++;
          $display("FAIL sb%0d_empty_full got %b%b required %b%b at %0t", g, emp_w[g], full_w[g],
                   sz == 0, sz == MD, $time);
        end
      end
      if (rst) begin
        exp_q.delete();
        ovf_m = 0; in_flight = 0; busy_seen = 0; start_due = 0;
        last_tx = 8'h00;
        valid = 1'b1;
      end else if (valid) begin
        pop_m  = start_due;
        drop_m = rx_rdy[g] && (sz == MD) && !pop_m;
        if (pop_m) begin
          last_tx = exp_q.pop_front();
          n_tx++;
        end
        if (rx_rdy[g] && !drop_m) exp_q.push_back(rx_d[g]);
        ovf_m = (ovf_m && !clr_v[g]) || drop_m;
        nxt = 0;
        if (start_due) busy_seen = 0;
        else if (!in_flight) begin
          if (send_v[g] && sz != 0) begin
            nxt = 1;
            in_flight = 1;
          end
        end else if (!busy_seen) busy_seen = busy_w[g];
        else if (!busy_w[g]) begin
          if (MB && sz != 0) nxt = 1;
          else in_flight = 0;
        end
        start_due = nxt;
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int d, input logic [7:0] v);
    rx_rdy[d] = 1'b1;
    rx_d[d]   = v;
    step(1);
    rx_rdy[d] = 1'b0;
  endtask

  task automatic clear_inputs();
    rx_rdy = '0; rx_d = '0; send_v = '0; clr_v = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int k;
    k = 0;
    while ((state_w[d] !== 2'd0 || busy_w[d] !== 1'b0) && k < 200) begin
      step(1);
      k++;
    end
    n_tests++;
    if (k >= 200) begin
      n_fail++;
      $display("FAIL wait_idle%0d timeout state=%0d required 0", d, state_w[d]);
    end
  endtask

  task automatic send_get(input int d, output logic [7:0] data, output logic seen);
    send_v[d] = 1'b1;
    step(1);
    send_v[d] = 1'b0;
    seen = txs_w[d];
    data = txd_w[d];
    wait_idle(d);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_rdy = 2'b11; rx_d = {8'h5A, 8'hA5}; send_v = 2'b11; clr_v = 2'b11;
    step(2);
    rst = 1'b0;
    clear_inputs();
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if ({txs_w[d], txd_w[d], cnt_w[d], emp_w[d], full_w[d], ovf_w[d], state_w[d]}
          !== {1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0}) begin
        n_fail++;
        $display("FAIL reset%0d got st=%b cnt=%0d e=%b f=%b o=%b txs=%b txd=%h required idle/0/1/0/0/0/00",
                 d, state_w[d], cnt_w[d], emp_w[d], full_w[d], ovf_w[d], txs_w[d], txd_w[d]);
      end
    end
  endtask

  task automatic test_single_send();
    int extra;
    do_reset();
    push(0, 8'h41); push(0, 8'h42); push(0, 8'h43);
    n_tests++;
    if (cnt_w[0] !== 5'd3) begin
      n_fail++; $display("FAIL single_count_pre got %0d required 3", cnt_w[0]);
    end
    send_v[0] = 1'b1;
    step(1);
    send_v[0] = 1'b0;
    n_tests++;
    if ({txs_w[0], txd_w[0]} !== {1'b1, 8'h41}) begin
      n_fail++; $display("FAIL single_start got txs=%b txd=%h required 1/41", txs_w[0], txd_w[0]);
    end
    step(1);
    n_tests++;
    if ({txs_w[0], cnt_w[0]} !== {1'b0, 5'd2}) begin
      n_fail++; $display("FAIL single_after got txs=%b cnt=%0d required 0/2", txs_w[0], cnt_w[0]);
    end
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (txs_w[0]) extra++;
    end
    n_tests++;
    if (extra != 0 || cnt_w[0] !== 5'd2 || state_w[0] !== 2'd0) begin
      n_fail++;
      $display("FAIL single_no_more got starts=%0d cnt=%0d st=%0d required 0/2/0", extra, cnt_w[0], state_w[0]);
    end
  endtask

  task automatic test_burst();
    logic [7:0] got [4];
    int starts;
    bit busy_since;
    do_reset();
    for (int i = 0; i < 4; i++) push(1, 8'h10 + 8'(i));
    send_v[1] = 1'b1;
    step(1);
    send_v[1] = 1'b0;
    starts = 0;
    busy_since = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if (txs_w[1]) begin
        n_tests++;
        if (!busy_since || busy_w[1] !== 1'b0) begin
          n_fail++; $display("FAIL burst_gap start %0d got busy_seen=%b busy=%b required 1/0", starts, busy_since, busy_w[1]);
        end
        if (starts < 4) got[starts] = txd_w[1];
        starts++;
        busy_since = 1'b0;
      end
      if (busy_w[1]) busy_since = 1'b1;
      step(1);
    end
    n_tests++;
    if (starts != 4) begin
      n_fail++; $display("FAIL burst_starts got %0d required 4", starts);
    end
    for (int i = 0; i < 4 && i < starts; i++) begin
      n_tests++;
      if (got[i] !== 8'h10 + 8'(i)) begin
        n_fail++; $display("FAIL burst_data%0d got %h required %h", i, got[i], 8'h10 + 8'(i));
      end
    end
    n_tests++;
    if (emp_w[1] !== 1'b1 || state_w[1] !== 2'd0) begin
      n_fail++; $display("FAIL burst_end got empty=%b st=%0d required 1/0", emp_w[1], state_w[1]);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] data;
    logic seen;
    do_reset();
    for (int i = 0; i < 5; i++) push(0, 8'hA0 + 8'(i));
    n_tests++;
    if ({full_w[0], cnt_w[0], ovf_w[0]} !== {1'b1, 5'd4, 1'b1}) begin
      n_fail++; $display("FAIL ovf_set got full=%b cnt=%0d ovf=%b required 1/4/1", full_w[0], cnt_w[0], ovf_w[0]);
    end
    clr_v[0] = 1'b1;
    step(1);
    clr_v[0] = 1'b0;
    n_tests++;
    if (ovf_w[0] !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear got %b required 0", ovf_w[0]);
    end
    clr_v[0] = 1'b1;
    push(0, 8'hA5);
    clr_v[0] = 1'b0;
    n_tests++;
    if (ovf_w[0] !== 1'b1) begin
      n_fail++; $display("FAIL ovf_clr_vs_drop got %b required 1", ovf_w[0]);
    end
    clr_v[0] = 1'b1;
    step(1);
    clr_v[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_get(0, data, seen);
      n_tests++;
      if ({seen, data} !== {1'b1, 8'hA0 + 8'(i)}) begin
        n_fail++; $display("FAIL ovf_drain%0d got start=%b data=%h required 1/%h", i, seen, data, 8'hA0 + 8'(i));
      end
    end
    n_tests++;
    if (emp_w[0] !== 1'b1) begin
      n_fail++; $display("FAIL ovf_drain_empty got %b required 1", emp_w[0]);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] data;
    logic seen;
    do_reset();
    for (int i = 0; i < 4; i++) push(0, 8'hB0 + 8'(i));
    send_v[0] = 1'b1;
    step(1);
    send_v[0] = 1'b0;
    n_tests++;
    if ({txs_w[0], txd_w[0]} !== {1'b1, 8'hB0}) begin
      n_fail++; $display("FAIL fpp_start got txs=%b txd=%h required 1/b0", txs_w[0], txd_w[0]);
    end
    push(0, 8'hB4);
    n_tests++;
    if ({cnt_w[0], ovf_w[0]} !== {5'd4, 1'b0}) begin
      n_fail++; $display("FAIL fpp_count got cnt=%0d ovf=%b required 4/0", cnt_w[0], ovf_w[0]);
    end
    wait_idle(0);
    for (int i = 1; i < 5; i++) begin
      send_get(0, data, seen);
      n_tests++;
      if ({seen, data} !== {1'b1, 8'hB0 + 8'(i)}) begin
        n_fail++; $display("FAIL fpp_drain%0d got start=%b data=%h required 1/%h", i, seen, data, 8'hB0 + 8'(i));
      end
    end
  endtask

  task automatic test_ignored_send();
    int starts;
    int k;
    do_reset();
    send_v[0] = 1'b1;
    step(1);
    send_v[0] = 1'b0;
    starts = 0;
    for (int i = 0; i < 5; i++) begin
      if (txs_w[0]) starts++;
      step(1);
    end
    n_tests++;
    if (starts != 0 || state_w[0] !== 2'd0) begin
      n_fail++; $display("FAIL ign_empty got starts=%0d st=%0d required 0/0", starts, state_w[0]);
    end
    push(0, 8'hC0); push(0, 8'hC1);
    send_v[0] = 1'b1;
    step(1);
    send_v[0] = 1'b0;
    k = 0;
    while (state_w[0] !== 2'd3 && k < 50) begin
      step(1);
      k++;
    end
    n_tests++;
    if (k >= 50) begin
      n_fail++; $display("FAIL ign_reach_wait_done timeout st=%0d required 3", state_w[0]);
    end
    send_v[0] = 1'b1;
    step(1);
    send_v[0] = 1'b0;
    starts = 0;
    for (int i = 0; i < 40; i++) begin
      if (txs_w[0]) starts++;
      step(1);
    end
    n_tests++;
    if (starts != 0 || cnt_w[0] !== 5'd1) begin
      n_fail++; $display("FAIL ign_wait_done got starts=%0d cnt=%0d required 0/1", starts, cnt_w[0]);
    end
  endtask

  task automatic test_reset_mid();
    int starts;
    do_reset();
    man_mode[1] = 1'b1;
    man_busy[1] = 1'b0;
    for (int i = 0; i < 4; i++) push(1, 8'hD0 + 8'(i));
    send_v[1] = 1'b1;
    step(1);
    send_v[1] = 1'b0;
    step(1);
    man_busy[1] = 1'b1;
    step(1);
    n_tests++;
    if ({state_w[1], cnt_w[1]} !== {2'd3, 5'd3}) begin
      n_fail++; $display("FAIL rmid_setup got st=%0d cnt=%0d required 3/3", state_w[1], cnt_w[1]);
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    n_tests++;
    if ({txs_w[1], txd_w[1], cnt_w[1], emp_w[1], full_w[1], ovf_w[1], state_w[1]}
        !== {1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 2'd0}) begin
      n_fail++;
      $display("FAIL rmid_reset got st=%0d cnt=%0d e=%b f=%b o=%b txs=%b txd=%h required 0/0/1/0/0/0/00",
               state_w[1], cnt_w[1], emp_w[1], full_w[1], ovf_w[1], txs_w[1], txd_w[1]);
    end
    man_busy[1] = 1'b0;
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (txs_w[1]) starts++;
    end
    n_tests++;
    if (starts != 0) begin
      n_fail++; $display("FAIL rmid_no_start got %0d required 0", starts);
    end
    man_mode[1] = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) busy_len = $urandom_range(1, 6);
      for (int d = 0; d < 2; d++) begin
        rx_rdy[d] = ($urandom_range(0, 99) < 35);
        rx_d[d]   = 8'($urandom_range(0, 255));
        send_v[d] = ($urandom_range(0, 99) < 8);
        clr_v[d]  = ($urandom_range(0, 99) < 3);
      end
      rst = ($urandom_range(0, 999) == 0);
      step(1);
    end
    clear_inputs();
    rst = 1'b0;
    wait_idle(0);
    wait_idle(1);
    n_tests++;
    if (cnt_w[0] !== 5'(g_sb[0].exp_q.size())) begin
      n_fail++; $display("FAIL rand_count0 got %0d required %0d", cnt_w[0], g_sb[0].exp_q.size());
    end
    n_tests++;
    if (cnt_w[1] !== 5'(g_sb[1].exp_q.size())) begin
      n_fail++; $display("FAIL rand_count1 got %0d required %0d", cnt_w[1], g_sb[1].exp_q.size());
    end
    busy_len = 10;
  endtask

  initial begin
    man_mode = '0;
    man_busy = '0;
    clear_inputs();
    test_reset();
    test_single_send();
    test_burst();
    test_overflow();
    test_full_push_pop();
    test_ignored_send();
    test_reset_mid();
    test_random();
    step(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
